// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: prefetches each visible line from pixel memory into a
// ping-pong line buffer during the previous line, and presents registered RGB
// to the timing generator aligned to its position counters.
module vga_line_fetcher #(
  parameter int H_BACK_PORCH   = 48,
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_BACK_PORCH   = 33,
  parameter int V_VISIBLE_AREA = 480,
  parameter int H_REG_WIDTH    = 11,
  parameter int V_REG_WIDTH    = 11,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic [H_REG_WIDTH:0]    in_h_position,
  input  logic [V_REG_WIDTH:0]    in_v_position,
  output logic                    out_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   out_mem_req_addr,
  input  logic                    in_mem_req_ready,
  input  logic                    in_mem_rsp_valid,
  input  logic [11:0]             in_mem_rsp_data,
  output logic [3:0]              out_vga_r,
  output logic [3:0]              out_vga_g,
  output logic [3:0]              out_vga_b,
  output logic                    out_busy,
  output logic                    out_underflow
);

  localparam int COL_W = (H_VISIBLE_AREA > 1) ? $clog2(H_VISIBLE_AREA) : 1;
  // One extra bit so position + 1 never overflows before comparison.
  localparam int HP_W  = H_REG_WIDTH + 2;
  localparam int VP_W  = V_REG_WIDTH + 2;

  localparam logic [VP_W-1:0]  TRIG_V_LO = VP_W'(V_BACK_PORCH - 1);
  localparam logic [VP_W-1:0]  TRIG_V_HI = VP_W'(V_BACK_PORCH + V_VISIBLE_AREA - 2);
  localparam logic [VP_W-1:0]  VIS_V_LO  = VP_W'(V_BACK_PORCH);
  localparam logic [VP_W-1:0]  VIS_V_HI  = VP_W'(V_BACK_PORCH + V_VISIBLE_AREA - 1);
  localparam logic [HP_W-1:0]  COL_LO    = HP_W'(H_BACK_PORCH);
  localparam logic [HP_W-1:0]  COL_END   = HP_W'(H_BACK_PORCH + H_VISIBLE_AREA);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(H_VISIBLE_AREA - 1);
  // Parity of the back porch decides which buffer a given line maps to.
  localparam logic             VBP_ODD   = ((V_BACK_PORCH % 2) == 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   base;
  logic [COL_W-1:0]        req_col;
  logic [COL_W-1:0]        rsp_col;
  logic                    fetch_sel;

  logic [11:0]             line_buf [2][H_VISIBLE_AREA];

  logic [VP_W-1:0]         v_ext;
  logic [HP_W-1:0]         h_next;
  logic [VP_W-1:0]         trig_row;
  logic                    trigger;
  logic                    accept;
  logic                    rsp_take;
  logic                    last_req;
  logic                    last_rsp;

  logic                    vld_p0;
  logic                    disp_sel_p0;
  logic [COL_W-1:0]        col_p0;
  logic [11:0]             pix_p0;

  assign v_ext    = VP_W'(in_v_position);
  assign h_next   = HP_W'(in_h_position) + HP_W'(1);
  assign trig_row = v_ext + VP_W'(1) - VIS_V_LO;
  assign trigger  = (in_h_position == '0) && (v_ext >= TRIG_V_LO) && (v_ext <= TRIG_V_HI);
  assign accept   = (state == REQ) && in_mem_req_ready;
  assign rsp_take = (state != IDLE) && in_mem_rsp_valid;
  assign last_req = (req_col == LAST_COL);
  assign last_rsp = (rsp_col == LAST_COL);

  // FSM state register.
  always_ff @(posedge clk_pixel) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: a request burst of one line, then wait for all responses.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (trigger) state_nxt = REQ;
      REQ:   if (accept && last_req) state_nxt = (rsp_take && last_rsp) ? IDLE : DRAIN;
      DRAIN: if (rsp_take && last_rsp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: request address is held stable until it is accepted.
  always_comb begin
    out_mem_req_valid = (state == REQ);
    out_busy          = (state != IDLE);
    out_mem_req_addr  = base + ADDR_WIDTH'(req_col);
  end

  // Fetch bookkeeping: latch the row on trigger, advance columns, flag skipped lines.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      base          <= '0;
      req_col       <= '0;
      rsp_col       <= '0;
      fetch_sel     <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (trigger && (state != IDLE)) out_underflow <= 1'b1;
      if (trigger && (state == IDLE)) begin
        base      <= ADDR_WIDTH'(trig_row) * ADDR_WIDTH'(H_VISIBLE_AREA);
        req_col   <= '0;
        rsp_col   <= '0;
        fetch_sel <= ~(in_v_position[0] ^ VBP_ODD);
      end else begin
        if (accept)   req_col <= req_col + COL_W'(1);
        if (rsp_take) rsp_col <= rsp_col + COL_W'(1);
      end
    end
  end

  // Line buffer write port; contents are not reset.
  always_ff @(posedge clk_pixel) begin
    if (rsp_take) line_buf[fetch_sel][rsp_col] <= in_mem_rsp_data;
  end

  // Stage p0: look one column ahead so the registered colour lines up with P.
  always_comb begin
    vld_p0      = (v_ext >= VIS_V_LO) && (v_ext <= VIS_V_HI) &&
                  (h_next >= COL_LO) && (h_next < COL_END);
    disp_sel_p0 = in_v_position[0] ^ VBP_ODD;
    col_p0      = COL_W'(h_next - COL_LO);
    pix_p0      = vld_p0 ? line_buf[disp_sel_p0][col_p0] : 12'h000;
  end

  // Stage p1: registered colour, blanked outside the visible window.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      out_vga_r <= '0;
      out_vga_g <= '0;
      out_vga_b <= '0;
    end else begin
      out_vga_r <= pix_p0[11:8];
      out_vga_g <= pix_p0[7:4];
      out_vga_b <= pix_p0[3:0];
    end
  end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher with a compact timing geometry so that
// several complete frames fit in a short run. The stimulus process drives the
// position counters and a memory model and pushes expected requests/pixels;
// a separate monitor pops and compares them.
module tb_vga_line_fetcher;

  localparam int HBP = 6;
  localparam int HVA = 16;
  localparam int HT  = 40;
  localparam int VBP = 3;
  localparam int VVA = 8;
  localparam int VT  = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] in_h_position;
  logic [11:0] in_v_position;
  logic        out_mem_req_valid;
  logic [18:0] out_mem_req_addr;
  logic        in_mem_req_ready;
  logic        in_mem_rsp_valid;
  logic [11:0] in_mem_rsp_data;
  logic [3:0]  out_vga_r, out_vga_g, out_vga_b;
  logic        out_busy;
  logic        out_underflow;

  always #5 clk = ~clk;

  vga_line_fetcher #(
    .H_BACK_PORCH(HBP), .H_VISIBLE_AREA(HVA), .V_BACK_PORCH(VBP), .V_VISIBLE_AREA(VVA),
    .H_REG_WIDTH(11), .V_REG_WIDTH(11), .ADDR_WIDTH(19)
  ) dut (
    .clk_pixel(clk), .reset(reset),
    .in_h_position(in_h_position), .in_v_position(in_v_position),
    .out_mem_req_valid(out_mem_req_valid), .out_mem_req_addr(out_mem_req_addr),
    .in_mem_req_ready(in_mem_req_ready), .in_mem_rsp_valid(in_mem_rsp_valid),
    .in_mem_rsp_data(in_mem_rsp_data),
    .out_vga_r(out_vga_r), .out_vga_g(out_vga_g), .out_vga_b(out_vga_b),
    .out_busy(out_busy), .out_underflow(out_underflow)
  );

  typedef struct { bit chk; int v; int h; logic [11:0] exp; } pix_t;
  typedef struct { int due; logic [11:0] data; } rsp_t;

  pix_t        pixq[$];
  rsp_t        pend[$];
  int          addrq[$];
  int          checks = 0;
  int          passed = 0;

  int          hpos, vpos, cyc, mem_lat, skip_row;
  bit          ready_toggle, ready_low, pix_en;
  logic [11:0] cur_salt;
  logic [11:0] row_salt [VVA];
  int          disp_src [VVA];
  pix_t        mon_e;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [11:0] pix(int r, int c);
    return 12'(r * HVA + c) ^ row_salt[r];
  endfunction

  // One pixel clock: advance position, queue expectations, run memory model.
  task automatic step();
    int   r;
    pix_t e;
    rsp_t p;
    @(posedge clk); #1;
    cyc++;
    if (hpos == HT - 1) begin
      hpos = 0;
      vpos = (vpos == VT - 1) ? 0 : vpos + 1;
    end else hpos++;
    in_h_position = 12'(hpos);
    in_v_position = 12'(vpos);
    if (hpos == 0 && vpos == 0) cur_salt = cur_salt ^ 12'h5A5;
    if (hpos == 0 && vpos >= VBP - 1 && vpos <= VBP + VVA - 2) begin
      r = vpos + 1 - VBP;
      if (r != skip_row) begin
        row_salt[r] = cur_salt;
        for (int c = 0; c < HVA; c++) addrq.push_back(r * HVA + c);
      end
    end
    e.chk = pix_en; e.v = vpos; e.h = hpos; e.exp = 12'h000;
    if (vpos >= VBP && vpos < VBP + VVA && hpos >= HBP && hpos < HBP + HVA) begin
      r = vpos - VBP;
      if (disp_src[r] < 0) e.chk = 1'b0;
      else e.exp = pix(disp_src[r], hpos - HBP);
    end
    pixq.push_back(e);
    in_mem_req_ready = ready_low ? 1'b0 : (ready_toggle ? ((cyc % 2) == 0) : 1'b1);
    if (out_mem_req_valid && in_mem_req_ready) begin
      p.due  = cyc + mem_lat;
      p.data = out_mem_req_addr[11:0] ^ cur_salt;
      pend.push_back(p);
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      in_mem_rsp_valid = 1'b1;
      in_mem_rsp_data  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      in_mem_rsp_valid = 1'b0;
      in_mem_rsp_data  = 12'h000;
    end
  endtask

  task automatic run_until(int v, int h);
    int n;
    n = 0;
    step();
    while (!(vpos == v && hpos == h)) begin
      step();
      n++;
      if (n > HT * VT + 2) begin
        check("run_until_timeout", n, 0);
        return;
      end
    end
  endtask

  // Monitor: compare every presented pixel and every accepted request.
  always @(negedge clk) begin
    if (pixq.size() > 0) begin
      mon_e = pixq.pop_front();
      if (mon_e.chk)
        check($sformatf("pixel_v%0d_h%0d", mon_e.v, mon_e.h),
              int'({out_vga_r, out_vga_g, out_vga_b}), int'(mon_e.exp));
    end
    if (!reset && out_mem_req_valid && in_mem_req_ready) begin
      if (addrq.size() == 0) check("req_unexpected", int'(out_mem_req_addr), -1);
      else check("req_addr", int'(out_mem_req_addr), addrq.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_h_position = '0; in_v_position = '0;
    in_mem_req_ready = 1'b0; in_mem_rsp_valid = 1'b0; in_mem_rsp_data = '0;
    hpos = 0; vpos = 0; cyc = 0; mem_lat = 0; skip_row = -1;
    ready_toggle = 1'b0; ready_low = 1'b0; pix_en = 1'b0; cur_salt = '0;
    for (int r = 0; r < VVA; r++) begin disp_src[r] = -1; row_salt[r] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_valid", out_mem_req_valid, 0);
    check("rst_addr", int'(out_mem_req_addr), 0);
    check("rst_vga", int'({out_vga_r, out_vga_g, out_vga_b}), 0);
    check("rst_busy", out_busy, 0);
    check("rst_underflow", out_underflow, 0);

    // Zero-latency, always-ready memory: first row fetch and display.
    pix_en = 1'b1; disp_src[0] = 0; disp_src[1] = 1;
    hpos = HT - 1; vpos = VBP - 2;
    step();
    check("busy_in_trigger_cycle", out_busy, 0);
    step();
    check("busy_after_trigger", out_busy, 1);
    check("valid_after_trigger", out_mem_req_valid, 1);
    check("first_addr", int'(out_mem_req_addr), 0);
    run_until(VBP, HT - 1);
    check("underflow_t1", out_underflow, 0);

    // Ready alternating, 3-cycle response latency, across a frame wrap.
    mem_lat = 3; ready_toggle = 1'b1;
    for (int r = 0; r < VVA; r++) disp_src[r] = r;
    run_until(0, 0);
    run_until(VBP + VVA, HT - 1);
    check("underflow_toggle", out_underflow, 0);
    check("reqs_done_toggle", addrq.size(), 0);

    // Stalled memory during row 5 fetch causes row 6 to be skipped.
    ready_toggle = 1'b0; skip_row = 6; disp_src[5] = -1; disp_src[6] = 4;
    run_until(VBP + 4, 3);
    ready_low = 1'b1;
    run_until(VBP + 5, 0);
    check("underflow_before_trigger", out_underflow, 0);
    check("busy_at_second_trigger", out_busy, 1);
    step();
    check("underflow_rises", out_underflow, 1);
    run_until(VBP + 5, 8);
    ready_low = 1'b0;
    run_until(VBP + 5, HT - 1);
    check("row5_complete", addrq.size(), 0);
    check("idle_after_row5", out_busy, 0);
    run_until(VBP + VVA, HT - 1);
    check("underflow_sticky", out_underflow, 1);

    // Reset in the middle of a request burst (row 2, column 8).
    skip_row = -1; disp_src[5] = 5; disp_src[6] = 6; disp_src[2] = -1;
    run_until(VBP + 1, 9);
    check("mid_req_addr", int'(out_mem_req_addr), 2 * HVA + 8);
    reset = 1'b1; pix_en = 1'b0; addrq.delete();
    step();
    reset = 1'b0;
    check("abort_valid", out_mem_req_valid, 0);
    check("abort_busy", out_busy, 0);
    check("abort_underflow", out_underflow, 0);
    step();
    pix_en = 1'b1;
    run_until(VBP + 2, 0);
    step();
    check("restart_valid", out_mem_req_valid, 1);
    check("restart_addr", int'(out_mem_req_addr), 3 * HVA);

    // Last row fetch and no trigger on the last visible line.
    run_until(VBP + VVA - 2, 0);
    step();
    check("last_row_addr", int'(out_mem_req_addr), (VVA - 1) * HVA);
    run_until(VBP + VVA - 1, 1);
    check("no_trigger_last_valid", out_mem_req_valid, 0);
    check("no_trigger_last_busy", out_busy, 0);
    run_until(VBP + VVA, HT - 1);

    // Back-to-back frames with per-frame data so stale content shows up.
    disp_src[2] = 2;
    run_until(VBP + VVA, HT - 1);
    run_until(VBP + VVA, HT - 1);
    check("underflow_final", out_underflow, 0);
    check("reqs_done_final", addrq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
